// File: rtl/pc_fetch_stage.sv
// Fetch-stage program counter and IF/ID pipeline register.
// Next PC always comes from the external mux; a small FSM sequences boot, run and halt.
module pc_fetch_stage #(
    parameter int unsigned nbits  = 7,
    parameter int unsigned iwidth = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [nbits-1:0]  pc_next_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              halt_req_i,
    input  logic              resume_i,
    input  logic [iwidth-1:0] imem_data_i,
    output logic [nbits-1:0]  pc_o,
    output logic [nbits-1:0]  pc_inc_o,
    output logic [nbits-1:0]  ifid_pc_o,
    output logic [iwidth-1:0] ifid_instr_o,
    output logic              ifid_valid_o,
    output logic              halted_o
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e              state_q, state_d;
    logic [nbits-1:0]    pc_q, pc_d;
    logic [nbits-1:0]    ifid_pc_q, ifid_pc_d;
    logic [iwidth-1:0]   ifid_instr_q, ifid_instr_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic                halted_q, halted_d;

    // Wraps modulo 2^nbits; the carry out is discarded.
    assign pc_inc_o = pc_q + {{(nbits-1){1'b0}}, 1'b1};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        halted_d     = halted_q;
        unique case (state_q)
            StBoot: begin
                state_d      = StRun;
                ifid_valid_d = 1'b0;
            end
            StRun: begin
                if (flush_i) begin
                    pc_d         = pc_next_i;
                    ifid_valid_d = 1'b0;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (halt_req_i) begin
                    ifid_valid_d = 1'b0;
                    halted_d     = 1'b1;
                    state_d      = StHalt;
                end else begin
                    pc_d         = pc_next_i;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_data_i;
                    ifid_valid_d = 1'b1;
                end
            end
            StHalt: begin
                // Fetch restarts at the held pc on the edge after resume.
                ifid_valid_d = 1'b0;
                halted_d     = 1'b1;
                if (resume_i) begin
                    state_d  = StRun;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StBoot;
            pc_q         <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign pc_o         = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: boot, sequential fetch, wrap, stall, flush, halt, async reset.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [6:0]  pc_next;
    logic        stall;
    logic        flush;
    logic        halt_req;
    logic        resume;
    logic [15:0] imem_data;
    logic [6:0]  pc;
    logic [6:0]  pc_inc;
    logic [6:0]  ifid_pc;
    logic [15:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;

    logic        use_ovr;
    logic [6:0]  ovr_pc;

    int n_vec;
    int n_err;

    // Sequential flow unless a test forces a target address.
    assign pc_next   = use_ovr ? ovr_pc : pc_inc;
    assign imem_data = 16'h0100 + {9'b0, pc};

    pc_fetch_stage #(
        .nbits  (7),
        .iwidth (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_next_i    (pc_next),
        .stall_i      (stall),
        .flush_i      (flush),
        .halt_req_i   (halt_req),
        .resume_i     (resume),
        .imem_data_i  (imem_data),
        .pc_o         (pc),
        .pc_inc_o     (pc_inc),
        .ifid_pc_o    (ifid_pc),
        .ifid_instr_o (ifid_instr),
        .ifid_valid_o (ifid_valid),
        .halted_o     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        halt_req = 1'b0;
        resume   = 1'b0;
        use_ovr  = 1'b0;
        ovr_pc   = 7'd0;
        step();
        step();
        check("rst_pc", {9'b0, pc}, 16'd0);
        check("rst_ifid_pc", {9'b0, ifid_pc}, 16'd0);
        check("rst_ifid_instr", ifid_instr, 16'd0);
        check("rst_valid", {15'b0, ifid_valid}, 16'd0);
        check("rst_halted", {15'b0, halted}, 16'd0);

        rst_n = 1'b1;
        step();
        check("boot_pc", {9'b0, pc}, 16'd0);
        check("boot_valid", {15'b0, ifid_valid}, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", {9'b0, pc}, 16'(i));
            check("seq_ifid_pc", {9'b0, ifid_pc}, 16'(i - 1));
            check("seq_instr", ifid_instr, 16'h0100 + 16'(i - 1));
            check("seq_valid", {15'b0, ifid_valid}, 16'd1);
        end

        step();
        step();
        check("pre_stall_pc", {9'b0, pc}, 16'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", {9'b0, pc}, 16'd5);
            check("stall_ifid_pc", {9'b0, ifid_pc}, 16'd4);
            check("stall_valid", {15'b0, ifid_valid}, 16'd1);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", {9'b0, pc}, 16'd6);
        check("unstall_ifid_pc", {9'b0, ifid_pc}, 16'd5);

        step();
        step();
        check("pre_flush_pc", {9'b0, pc}, 16'd8);
        use_ovr = 1'b1;
        ovr_pc  = 7'd40;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        use_ovr = 1'b0;
        check("flush_pc", {9'b0, pc}, 16'd40);
        check("flush_valid", {15'b0, ifid_valid}, 16'd0);
        step();
        check("post_flush_ifid_pc", {9'b0, ifid_pc}, 16'd40);
        check("post_flush_valid", {15'b0, ifid_valid}, 16'd1);
        check("post_flush_pc", {9'b0, pc}, 16'd41);

        use_ovr = 1'b1;
        ovr_pc  = 7'd40;
        flush   = 1'b1;
        stall   = 1'b1;
        step();
        flush   = 1'b0;
        stall   = 1'b0;
        use_ovr = 1'b0;
        check("flush_stall_pc", {9'b0, pc}, 16'd40);
        check("flush_stall_valid", {15'b0, ifid_valid}, 16'd0);
        step();
        check("post_fs_ifid_pc", {9'b0, ifid_pc}, 16'd40);
        check("post_fs_valid", {15'b0, ifid_valid}, 16'd1);

        use_ovr = 1'b1;
        ovr_pc  = 7'd10;
        step();
        use_ovr = 1'b0;
        check("pre_halt_pc", {9'b0, pc}, 16'd10);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_halted", {15'b0, halted}, 16'd1);
        check("halt_pc", {9'b0, pc}, 16'd10);
        check("halt_valid", {15'b0, ifid_valid}, 16'd0);
        use_ovr = 1'b1;
        ovr_pc  = 7'd99;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        use_ovr = 1'b0;
        check("halt_flush_pc", {9'b0, pc}, 16'd10);
        check("halt_flush_halted", {15'b0, halted}, 16'd1);
        check("halt_flush_valid", {15'b0, ifid_valid}, 16'd0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_halted", {15'b0, halted}, 16'd0);
        check("resume_pc", {9'b0, pc}, 16'd10);
        step();
        check("restart_ifid_pc", {9'b0, ifid_pc}, 16'd10);
        check("restart_instr", ifid_instr, 16'h010a);
        check("restart_valid", {15'b0, ifid_valid}, 16'd1);
        check("restart_pc", {9'b0, pc}, 16'd11);

        use_ovr = 1'b1;
        ovr_pc  = 7'd126;
        step();
        use_ovr = 1'b0;
        step();
        check("wrap_pc", {9'b0, pc}, 16'd127);
        check("wrap_pc_inc", {9'b0, pc_inc}, 16'd0);
        step();
        check("wrap_next_pc", {9'b0, pc}, 16'd0);
        check("wrap_ifid_pc", {9'b0, ifid_pc}, 16'd127);
        check("wrap_instr", ifid_instr, 16'h017f);

        use_ovr = 1'b1;
        ovr_pc  = 7'd20;
        step();
        use_ovr = 1'b0;
        check("pre_areset_pc", {9'b0, pc}, 16'd20);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_pc", {9'b0, pc}, 16'd0);
        check("areset_valid", {15'b0, ifid_valid}, 16'd0);
        check("areset_halted", {15'b0, halted}, 16'd0);
        check("areset_ifid_pc", {9'b0, ifid_pc}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Fetch-stage program counter for the pipeline. Holds the PC and drives the instruction-memory address.
- Generates PC+1, which is the sequential candidate fed to the next-PC select mux.
- Loads the mux's selected next PC every advancing cycle and registers {PC, instruction} into the IF/ID pipeline register.
- Handles hazard stall, branch flush and halt/resume through a small state machine.

Parameters:
- nbits, 7, PC / instruction-address width.
- iwidth, 16, instruction word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_next  input  nbits  selected next PC from the next-PC mux.
- stall  input  1  hazard-unit stall: hold PC and IF/ID.
- flush  input  1  branch taken: squash IF/ID, load pc_next.
- halt_req  input  1  halt instruction decoded.
- resume  input  1  leave HALT state.
- imem_data  input  iwidth  instruction read combinationally at address pc.
- pc  output  nbits  current PC, instruction-memory address.
- pc_inc  output  nbits  pc+1, feeds the mux sequential input.
- ifid_pc  output  nbits  PC of the instruction held in IF/ID.
- ifid_instr  output  iwidth  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID content is a real instruction.
- halted  output  1  high while in HALT.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: pc=0, ifid_pc=0, ifid_instr=0, ifid_valid=0, halted=0, state=BOOT. Reset asserted mid-operation clears all of these immediately, without waiting for a clock edge.
- pc_inc = (pc+1) mod 2^nbits, combinational. Wrap example: pc=2^nbits-1 gives pc_inc=0. No carry out.
- BOOT state:
  - Lasts exactly one clk edge after rst_n rises.
  - pc stays 0, ifid_valid stays 0.
  - Next state is RUN; all inputs are ignored.
- RUN state, evaluated at each rising edge in this priority order:
  1. flush=1: pc<=pc_next, ifid_valid<=0; ifid_pc and ifid_instr are don't-care. Flush overrides stall and halt_req in the same cycle.
  2. stall=1: pc, ifid_pc, ifid_instr and ifid_valid all hold.
  3. halt_req=1: pc holds, ifid_valid<=0, halted<=1, state<=HALT.
  4. Otherwise: pc<=pc_next, ifid_pc<=pc, ifid_instr<=imem_data, ifid_valid<=1.
- HALT state:
  - pc holds, ifid_valid=0, halted=1.
  - stall, flush and halt_req are ignored.
  - resume=1 at an edge: state<=RUN and halted<=0. Fetch restarts at the held pc on the following edge.
- Latency:
  - An instruction at address A appears in IF/ID one edge after pc=A, provided that cycle is not stalled or flushed.
  - A taken branch costs one bubble: the squashed slot has ifid_valid=0.
- All registered outputs change only on a clk edge or on the asynchronous reset.
- No internal path exists from pc_inc to pc. The PC always comes from pc_next, so the external mux must select pc_inc for sequential flow.

Test Plan:
- Reset/boot:
  - Stimulus: rst_n low, release; tie pc_next=pc_inc; imem_data=pc+16'h100.
  - Required: cycle after release pc=0 and ifid_valid=0.
  - Then pc=1,2,3 with ifid_pc=0,1,2, ifid_instr=16'h100,16'h101,16'h102, ifid_valid=1.
- Wrap-around (nbits=7):
  - Stimulus: sequential run to pc=127.
  - Required: pc_inc=0, next pc=0, ifid_pc=127.
- Stall:
  - Stimulus: stall=1 for 3 edges at pc=5.
  - Required: pc=5 and ifid_pc=4 hold for 3 edges; after release, pc=6 and ifid_pc=5.
- Flush and flush-over-stall:
  - Stimulus: at pc=8, pc_next=40, flush=1 (repeat once with stall=1 as well).
  - Required: pc=40, ifid_valid=0; on the next edge, ifid_pc=40 and ifid_valid=1.
- Halt/resume:
  - Stimulus: halt_req=1 at pc=10; flush=1 during HALT; then resume=1.
  - Required: halted=1, pc=10, ifid_valid=0, flush has no effect.
  - After resume, halted=0 and ifid_pc=10 on the following edge.
- Async reset mid-run:
  - Stimulus: drop rst_n between edges at pc=20.
  - Required: pc=0, ifid_valid=0, halted=0 immediately, before the next edge.
